// File: rtl/config_loader_pkg.sv
// Shared types and helpers for the slice configuration loader.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
// Optional build macro: CONFIG_LOADER_CRC_EN adds the CHECK state.
package config_loader_pkg;

    // Generator polynomial x^8 + x^2 + x + 1 for the serial config CRC
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
`ifdef CONFIG_LOADER_CRC_EN
        CHECK,
`endif
        DONE
    } state_t;

    // Number of bitstream words needed to fill the whole chain
    function automatic int words_needed(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/config_crc8.sv
// Serial CRC-8 over the config bits, one bit per enabled cycle, MSB-first shift.
// Latency: crc reflects a bit on the cycle after bit_en; clear wins over bit_en.
// Backpressure: none; it observes the chain and never stalls it.
module config_crc8
    import config_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic       fb;

    // Next CRC value: shift in one bit, fold in the polynomial on feedback
    always_comb begin
        fb    = crc_q[7] ^ bit_in;
        crc_d = crc_q;
        if (clear) begin
            crc_d = 8'h00;
        end else if (bit_en) begin
            crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
    end

    // CRC register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/config_loader.sv
// Loads a bitstream word by word and shifts it LSB-first into the slice config chain.
// Latency: one LOAD cycle per word plus one SHIFT cycle per chain bit, then one DONE cycle.
// Backpressure: in_ready only in LOAD (and CHECK); chain shifting pauses while in_valid is low.
// Optional build macro: CONFIG_LOADER_CRC_EN adds a CRC-8 check word after the last bit.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 69
) (
    input  logic              config_clk,
    input  logic              config_rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              config_en,
    output logic              config_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]  CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]  CHAIN_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [WCNT_W-1:0] WORD_LAST  = WCNT_W'(WORD_W - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]   word_bit_q, word_bit_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic                start_acc;

`ifdef CONFIG_LOADER_CRC_EN
    logic                err_q, err_d;
    logic [7:0]          crc_val;
`endif

    // Next-state, datapath updates and Moore outputs
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_bit_d = word_bit_q;
        shift_d    = shift_q;
        start_acc  = 1'b0;
        in_ready   = 1'b0;
        config_en  = 1'b0;
        done       = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    bit_cnt_d = '0;
`ifdef CONFIG_LOADER_CRC_EN
                    err_d     = 1'b0;
`endif
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d    = in_data;
                    word_bit_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                config_en  = 1'b1;
                shift_d    = shift_q >> 1;
                word_bit_d = word_bit_q + WCNT_W'(1);
                // Saturate so the counter can never wrap
                if (bit_cnt_q != CHAIN_FULL) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
                // Leave at the end of the word or when the chain is full,
                // whichever comes first; spare MSBs of the last word are dropped
                if (word_bit_q == WORD_LAST || bit_cnt_q >= CHAIN_LAST) begin
                    if (bit_cnt_q < CHAIN_LAST) begin
                        state_d = LOAD;
                    end else begin
`ifdef CONFIG_LOADER_CRC_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            CHECK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data[7:0] != crc_val) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge config_clk) begin
        if (!config_rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_bit_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_bit_q <= word_bit_d;
            shift_q    <= shift_d;
        end
    end

    // Serial bit is gated so the chain input idles low outside SHIFT
    assign config_out = config_en & shift_q[0];
    assign busy       = (state_q != IDLE);

`ifdef CONFIG_LOADER_CRC_EN
    // Sticky mismatch flag, cleared only by an accepted start
    always_ff @(posedge config_clk) begin
        if (!config_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

    config_crc8 u_crc (
        .clk    (config_clk),
        .rst_n  (config_rst_n),
        .clear  (start_acc),
        .bit_en (config_en),
        .bit_in (config_out),
        .crc    (crc_val)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: table of full loads plus reset and wide-word sequences.
// Latency: n/a (testbench).
// Backpressure: stalls in_valid on selected words.
module tb_config_loader;

`ifdef CONFIG_LOADER_CRC_EN
    localparam int CRC_ON = 1;
`else
    localparam int CRC_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, config_en, config_out, busy, done, err;

    logic        start2 = 1'b0;
    logic [15:0] in_data2 = 16'h0000;
    logic        in_valid2 = 1'b0;
    logic        in_ready2, config_en2, config_out2, busy2, done2, err2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    config_loader #(.WORD_W(8), .CHAIN_LEN(69)) dut (
        .config_clk(clk), .config_rst_n(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .config_en(config_en), .config_out(config_out), .busy(busy),
        .done(done), .err(err)
    );

    config_loader #(.WORD_W(16), .CHAIN_LEN(16)) dut16 (
        .config_clk(clk), .config_rst_n(rst_n), .start(start2),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .config_en(config_en2), .config_out(config_out2), .busy(busy2),
        .done(done2), .err(err2)
    );

    typedef struct {
        logic [71:0] words;        // word i lives in bits [8i+7:8i]
        int          stall_before; // word index whose delivery is delayed
        int          stall_len;    // LOAD cycles with in_valid low
        bit          restart;      // pulse start mid-SHIFT
        bit          crc_bad;      // corrupt the check word
    } vec_t;

    vec_t vecs[6];
    bit   last_bits[$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [7:0] model_crc(input logic [71:0] w, input int n);
        logic [7:0] c = 8'h00;
        logic fb;
        for (int i = 0; i < n; i++) begin
            fb = c[7] ^ w[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic run_load(input int vi);
        vec_t        vc = vecs[vi];
        logic [7:0]  words[10];
        bit          got[$];
        int          widx = 0, stall = vc.stall_len, k = 0;
        int          dones = 0, done_k = -1, bad_bits = 0, overlap = 0, idle_busy = 0;
        int          stall_en = 0;
        bit          fin = 1'b0;
        for (int i = 0; i < 9; i++) words[i] = vc.words[i*8 +: 8];
        words[9] = model_crc(vc.words, 69) ^ (vc.crc_bad ? 8'h5A : 8'h00);
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        while (!fin && k < 400) begin
            k++;
            if (k == 1) check($sformatf("v%0d err_cleared", vi), int'(err), 0);
            if (config_en) got.push_back(config_out);
            if (config_en && in_ready) overlap++;
            if (done) begin
                dones++;
                if (done_k < 0) done_k = k;
            end
            if (done_k < 0 && !busy) idle_busy++;
            start = (vc.restart && k == 30);
            if (widx == vc.stall_before && stall > 0 && in_ready) begin
                in_valid = 1'b0;
                stall--;
                if (config_en) stall_en++;
            end else begin
                in_valid = 1'b1;
                in_data  = words[widx < 10 ? widx : 9];
                if (in_ready) widx++;
            end
            if (done_k > 0 && k > done_k) begin
                fin = 1'b1;
                check($sformatf("v%0d busy_after_done", vi), int'(busy), 0);
                check($sformatf("v%0d err", vi), int'(err), CRC_ON & int'(vc.crc_bad));
            end
            if (!fin) @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        check($sformatf("v%0d finished_in_budget", vi), int'(fin), 1);
        check($sformatf("v%0d config_en_cycles", vi), got.size(), 69);
        for (int i = 0; i < 69; i++) begin
            if (i >= got.size() || got[i] != vc.words[i]) bad_bits++;
        end
        check($sformatf("v%0d bit_order_errors", vi), bad_bits, 0);
        check($sformatf("v%0d done_pulses", vi), dones, 1);
        check($sformatf("v%0d done_cycle", vi), done_k, 79 + vc.stall_len + CRC_ON);
        check($sformatf("v%0d ready_en_overlap", vi), overlap, 0);
        check($sformatf("v%0d busy_low_mid_load", vi), idle_busy, 0);
        check($sformatf("v%0d en_during_stall", vi), stall_en, 0);
        last_bits = got;
    endtask

    initial begin
        int ens, k, ones, loads2, done_k2, fin2;
        logic [15:0] got16;

        vecs[0] = '{72'h1F0000000000000001, -1, 0, 1'b0, 1'b0};
        vecs[1] = '{72'h1F0000000000000001,  3, 10, 1'b0, 1'b0};
        vecs[2] = '{72'h1F0000000000000001, -1, 0, 1'b1, 1'b0};
        vecs[3] = '{72'hA53C96F00F817EC35A, -1, 0, 1'b0, 1'b0};
        vecs[4] = '{72'h000000000000000000, -1, 0, 1'b0, 1'b1};
        vecs[5] = '{72'h000000000000000000, -1, 0, 1'b0, 1'b0};

        // Outputs while reset is held
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset in_ready", int'(in_ready), 0);
        check("reset config_en", int'(config_en), 0);
        check("reset config_out", int'(config_out), 0);
        check("reset done", int'(done), 0);
        check("reset err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_load(v);
            if (v == 0) begin
                ones = 0;
                for (int i = 64; i < 69 && i < last_bits.size(); i++) ones += int'(last_bits[i]);
                check("v0 first_bit", (last_bits.size() > 0) ? int'(last_bits[0]) : -1, 1);
                check("v0 last5_ones", ones, 5);
            end
        end

        // Reset after 20 shifted bits aborts the load at once
        @(negedge clk);
        start = 1'b1;
        ens = 0;
        k = 0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hFF;
        while (ens < 20 && k < 200) begin
            k++;
            if (config_en) ens++;
            if (ens == 20) rst_n = 1'b0;
            else @(negedge clk);
        end
        check("rst20 reached", ens, 20);
        @(negedge clk);
        check("rst20 config_en", int'(config_en), 0);
        check("rst20 busy", int'(busy), 0);
        check("rst20 in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        ens = 0;
        repeat (5) begin
            @(negedge clk);
            if (config_en) ens++;
        end
        check("rst20 no_en_after_abort", ens, 0);
        check("rst20 idle_after_abort", int'(busy), 0);
        in_valid = 1'b0;
        run_load(3);

        // 16-bit words, 16-bit chain: a single LOAD then 16 SHIFT cycles
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        in_valid2 = 1'b1;
        in_data2 = 16'hA5C3;
        ens = 0; loads2 = 0; done_k2 = -1; fin2 = 0; k = 0; got16 = 16'h0000;
        while (!fin2 && k < 100) begin
            k++;
            if (config_en2) begin
                if (ens < 16) got16[ens] = config_out2;
                ens++;
            end
            if (in_ready2 && ens < 16) loads2++;
            if (done2 && done_k2 < 0) done_k2 = k;
            if (done_k2 > 0 && k > done_k2) fin2 = 1;
            else @(negedge clk);
        end
        in_valid2 = 1'b0;
        check("w16 finished_in_budget", fin2, 1);
        check("w16 config_en_cycles", ens, 16);
        check("w16 load_cycles", loads2, 1);
        check("w16 serial_word", int'(got16), int'(16'hA5C3));
        check("w16 done_cycle", done_k2, 18 + CRC_ON);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, giving the bitstream input word width in bits.
REQ-002 The block SHALL have parameter CHAIN_LEN, default 69, giving the total config chain length in bits (4 LUTs x 17 config bits + 1 carry-chain enable bit).
REQ-003 The block SHALL have port config_clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port config_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a load; honoured only in IDLE.
REQ-006 The block SHALL have port in_data, input, WORD_W bits: bitstream word.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 The block SHALL have port config_en, output, 1 bit: shift-enable driven into the slice config chain.
REQ-010 The block SHALL have port config_out, output, 1 bit: serial config bit, valid whenever config_en=1.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a load.
REQ-013 The block SHALL have port err, output, 1 bit: CRC mismatch flag.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SHIFT, CHECK and DONE; CHECK exists only under CONFIG_LOADER_CRC_EN.
REQ-015 In IDLE, start=1 SHALL clear the bit counter, clear err and move to LOAD on the next edge.
REQ-016 In LOAD, in_ready SHALL be 1; in_valid=1 SHALL capture in_data into the shift register and move to SHIFT. in_ready SHALL be 0 in every other state.
REQ-017 In SHIFT, config_en SHALL be 1 and config_out SHALL be shift-register bit 0, i.e. word LSB first; the register shifts right and the bit counter increments each cycle.
REQ-018 SHIFT SHALL last WORD_W cycles, or fewer if the bit counter reaches CHAIN_LEN first. Unused MSBs of the last word are discarded: with defaults, 9 words and the last word uses bits [4:0].
REQ-019 On leaving SHIFT, the FSM SHALL go to LOAD if the bit counter is below CHAIN_LEN. Otherwise it SHALL go to CHECK when the macro is defined, else to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 config_en SHALL be 0 in every state except SHIFT; exactly CHAIN_LEN config_en cycles SHALL occur per completed load.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 With in_valid held high, the load SHALL take ceil(CHAIN_LEN/WORD_W) LOAD cycles plus CHAIN_LEN SHIFT cycles plus 1 DONE cycle (79 cycles with defaults, no CRC).
REQ-024 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.

Reset
REQ-025 config_rst_n=0 SHALL force the following on that edge: state=IDLE, in_ready=0, config_en=0, config_out=0, busy=0, done=0, err=0, counter and shift register cleared.
REQ-026 Reset mid-load SHALL abort immediately with no further config_en pulses. The partial chain content is undefined, and a full reload is required.

Configuration
REQ-027 Defining CONFIG_LOADER_CRC_EN SHALL compile in a serial CRC-8 (polynomial 0x07, init 0x00) over every bit driven on config_out while config_en=1, in shift order.
REQ-028 With the macro defined, CHECK SHALL assert in_ready and accept one extra word, whose low 8 bits are the expected CRC. On mismatch, err SHALL be set and held until the next accepted start; then the FSM SHALL go to DONE.
REQ-029 Without the macro, there SHALL be no CHECK state and no CRC logic, and err SHALL be tied to 0.

Structure
REQ-030 Package config_loader_pkg SHALL hold the state enum, the CRC8_POLY constant (8'h07) and a words-needed function computing ceil(CHAIN_LEN/WORD_W).
REQ-031 The serial CRC SHALL be a separate sub-module config_crc8 (inputs: clk, rst_n, clear, bit_en, bit_in; output crc[7:0]), instantiated only under the macro.

Verification
REQ-032 Defaults, no CRC; start pulse, words 0x01,0x00,...,0x1F supplied with in_valid constant -> 69 config_en cycles; first config_out=1 then 0s; last 5 bits =1; done pulses exactly at cycle 79.
REQ-033 in_valid withheld 10 cycles before word 3 -> config_en stays 0 during the stall; serial bit order is unchanged.
REQ-034 start asserted again during SHIFT -> ignored; still exactly 69 config_en cycles and a single done pulse.
REQ-035 config_rst_n=0 after 20 shifted bits -> next cycle config_en=0, busy=0, state IDLE; a subsequent full load completes normally.
REQ-036 CRC_EN, all-zero bitstream followed by CRC word 0x00 -> err=0; repeat with CRC word 0x5A -> err=1 and done still pulses.
REQ-037 WORD_W=16, CHAIN_LEN=16 -> one word, 16 SHIFT cycles, no second LOAD.
